// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: clk-domain SPI slave that writes the five PWM config registers.
// Define SPI_READBACK_EN to drive read-frame data back on cipo.
module spi_reg_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_REGS    = 5,
  parameter int FRAME_BITS  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic       cipo,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe,
  output logic       frame_err
);

  localparam int CW = $clog2(FRAME_BITS + 1);
  localparam logic [CW-1:0] FULL = CW'(FRAME_BITS);
  localparam logic [6:0] NREG = 7'(NUM_REGS);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] copi_sync_q;
  logic [SYNC_STAGES-1:0] ncs_sync_q;
  logic                   sclk_hist_q;
  logic                   ncs_hist_q;
  logic                   sclk_s, copi_s, ncs_s;
  logic                   sclk_rise, sclk_fall;
  logic                   ncs_rise, ncs_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      ncs_sync_q  <= '1;
      sclk_hist_q <= 1'b0;
      ncs_hist_q  <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
      sclk_hist_q <= sclk_s;
      ncs_hist_q  <= ncs_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign copi_s    = copi_sync_q[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist_q;
  assign sclk_fall = ~sclk_s & sclk_hist_q;
  assign ncs_rise  = ncs_s & ~ncs_hist_q;
  assign ncs_fall  = ~ncs_s & ncs_hist_q;

  state_e                state_q;
  logic [CW-1:0]         cnt_q;
  logic                  ovf_q;
  logic [FRAME_BITS-1:0] sr_q;
  logic [FRAME_BITS-1:0] sr_d;
  logic [7:0]            regs_q [5];
  logic                  wr_strobe_q;
  logic                  frame_err_q;
  logic                  rw;
  logic [6:0]            addr;
  logic [7:0]            wdata;
  logic                  wr_ok;

  assign sr_d  = {sr_q[FRAME_BITS-2:0], copi_s};
  assign rw    = sr_q[FRAME_BITS-1];
  assign addr  = sr_q[FRAME_BITS-2 -: 7];
  assign wdata = sr_q[7:0];
  assign wr_ok = rw && (addr < NREG);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      sr_q        <= '0;
      wr_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;
      for (int i = 0; i < 5; i++) regs_q[i] <= '0;
    end else begin
      wr_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (ncs_fall) begin
            state_q <= SHIFT;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
          end
        end
        SHIFT: begin
          // ncs_rise takes priority over a coincident sclk_rise
          if (ncs_rise) begin
            if (cnt_q == FULL && !ovf_q) begin
              state_q     <= COMMIT;
              wr_strobe_q <= wr_ok;
            end else begin
              state_q     <= IDLE;
              frame_err_q <= 1'b1;
            end
          end else if (sclk_rise) begin
            if (cnt_q == FULL) begin
              ovf_q <= 1'b1;
            end else begin
              sr_q  <= sr_d;
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        COMMIT: begin
          if (wr_ok) begin
            for (int i = 0; i < 5; i++)
              if (addr == 7'(i)) regs_q[i] <= wdata;
          end
          if (ncs_fall) begin
            state_q <= SHIFT;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SPI_READBACK_EN
  logic [7:0] tx_q;
  logic [6:0] rd_addr;
  logic [7:0] rd_val;

  assign rd_addr = sr_d[6:0];

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < 5; i++)
      if (rd_addr == 7'(i)) rd_val = regs_q[i];
  end

  // load on the 8th rise of a read frame, shift out on later falls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q <= '0;
    end else if (state_q != SHIFT || ncs_rise) begin
      tx_q <= '0;
    end else if (sclk_rise && cnt_q == CW'(7)) begin
      if (!sr_d[7] && rd_addr < NREG) tx_q <= rd_val;
    end else if (sclk_fall) begin
      tx_q <= {tx_q[6:0], 1'b0};
    end
  end

  assign cipo = tx_q[7];
`else
  assign cipo = 1'b0;
`endif

  assign en_reg_out_7_0  = regs_q[0];
  assign en_reg_out_15_8 = regs_q[1];
  assign en_reg_pwm_7_0  = regs_q[2];
  assign en_reg_pwm_15_8 = regs_q[3];
  assign pwm_duty_cycle  = regs_q[4];
  assign wr_strobe       = wr_strobe_q;
  assign frame_err       = frame_err_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb_spi_reg_ctrl: table vectors, hand sequences and random frames
// checked against a frame-level register model.
module tb_spi_reg_ctrl;

  localparam int PH = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       copi = 1'b0;
  logic       ncs = 1'b1;
  logic       cipo;
  logic [7:0] r0, r1, r2, r3, r4;
  logic       wr_strobe;
  logic       frame_err;

  spi_reg_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sclk            (sclk),
    .copi            (copi),
    .ncs             (ncs),
    .cipo            (cipo),
    .en_reg_out_7_0  (r0),
    .en_reg_out_15_8 (r1),
    .en_reg_pwm_7_0  (r2),
    .en_reg_pwm_15_8 (r3),
    .pwm_duty_cycle  (r4),
    .wr_strobe       (wr_strobe),
    .frame_err       (frame_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int n_str = 0;
  int n_err = 0;
  logic [7:0] model [5];
  logic cv [18];

  always @(negedge clk) begin
    if (wr_strobe) n_str++;
    if (frame_err) n_err++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [39:0] regs_cat();
    return {r4, r3, r2, r1, r0};
  endfunction

  function automatic logic [39:0] model_cat();
    return {model[4], model[3], model[2], model[1], model[0]};
  endfunction

  function automatic logic [7:0] cvec();
    logic [7:0] v = '0;
    for (int k = 7; k <= 14; k++) v = {v[6:0], cv[k]};
    return v;
  endfunction

  task automatic send_bits(input logic [17:0] w, input int nb);
    for (int k = 0; k < 18; k++) cv[k] = 1'b0;
    ncs = 1'b0;
    wait_clk(PH);
    for (int k = 0; k < nb; k++) begin
      copi = w[nb-1-k];
      wait_clk(PH);
      sclk = 1'b1;
      wait_clk(PH - 1);
      cv[k] = cipo;
      wait_clk(1);
      sclk = 1'b0;
    end
    wait_clk(PH);
  endtask

  task automatic frame(input logic [17:0] w, input int nb);
    send_bits(w, nb);
    ncs = 1'b1;
    wait_clk(12);
  endtask

  typedef struct {
    int          nb;
    logic [17:0] w;
    logic [39:0] regs;
    int          strobes;
    int          errs;
    logic [7:0]  cip;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int s0, e0, lat, st_at, sel, nb, es, ee;
    logic [17:0] w;
    logic [6:0]  a;
    logic [7:0]  ec;

    tbl[0] = '{16, 18'h080F0, 40'h00000000F0, 1, 0, 8'h00};
    tbl[1] = '{16, 18'h08480, 40'h80000000F0, 1, 0, 8'h00};
    tbl[2] = '{16, 18'h08255, 40'h80005500F0, 1, 0, 8'h00};
    tbl[3] = '{16, 18'h090AA, 40'h80005500F0, 0, 0, 8'h00};
    tbl[4] = '{12, 18'h00812, 40'h80005500F0, 0, 1, 8'h00};
    tbl[5] = '{17, 18'h10377, 40'h80005500F0, 0, 1, 8'h00};
    tbl[6] = '{16, 18'h0815A, 40'h8000555AF0, 1, 0, 8'h00};
`ifdef SPI_READBACK_EN
    tbl[7] = '{16, 18'h00100, 40'h8000555AF0, 0, 0, 8'h5A};
`else
    tbl[7] = '{16, 18'h00100, 40'h8000555AF0, 0, 0, 8'h00};
`endif

    wait_clk(4);
    chk("reset_regs", 64'(regs_cat()), 64'h0);
    chk("reset_strobe", 64'(wr_strobe), 64'h0);
    chk("reset_err", 64'(frame_err), 64'h0);
    chk("reset_cipo", 64'(cipo), 64'h0);
    rst_n = 1'b1;
    wait_clk(4);

    for (int i = 0; i < 8; i++) begin
      s0 = n_str;
      e0 = n_err;
      frame(tbl[i].w, tbl[i].nb);
      chk($sformatf("tbl%0d_regs", i), 64'(regs_cat()), 64'(tbl[i].regs));
      chk($sformatf("tbl%0d_strobe", i), 64'(n_str - s0), 64'(tbl[i].strobes));
      chk($sformatf("tbl%0d_err", i), 64'(n_err - e0), 64'(tbl[i].errs));
      chk($sformatf("tbl%0d_cipo", i), 64'(cvec()), 64'(tbl[i].cip));
    end
    for (int i = 0; i < 5; i++) model[i] = tbl[7].regs[i*8 +: 8];

    // commit latency after the nCS pin rises
    send_bits(18'h083A5, 16);
    ncs = 1'b1;
    lat = 0;
    st_at = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (wr_strobe) st_at = n;
      if (r3 == 8'hA5) begin
        lat = n;
        break;
      end
    end
    chk("latency_reg", 64'(lat), 64'd4);
    chk("latency_strobe", 64'(st_at), 64'd3);
    wait_clk(12);
    model[3] = 8'hA5;
    chk("latency_regs", 64'(regs_cat()), 64'(model_cat()));

    for (int t = 0; t < 30; t++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7) nb = 16;
      else if (sel == 7) nb = $urandom_range(0, 15);
      else nb = $urandom_range(17, 18);
      w = 18'($urandom);
      if ($urandom_range(0, 3) == 0) a = 7'($urandom);
      else a = 7'($urandom_range(0, 6));
      w[14:8] = a;
      es = 0;
      ee = 0;
      ec = 8'h00;
      if (nb != 16) begin
        ee = 1;
      end else if (w[15]) begin
        if (a < 7'd5) begin
          es = 1;
          model[a] = w[7:0];
        end
      end else begin
`ifdef SPI_READBACK_EN
        if (a < 7'd5) ec = model[a];
`endif
      end
      s0 = n_str;
      e0 = n_err;
      frame(w, nb);
      chk($sformatf("rnd%0d_regs", t), 64'(regs_cat()), 64'(model_cat()));
      chk($sformatf("rnd%0d_strobe", t), 64'(n_str - s0), 64'(es));
      chk($sformatf("rnd%0d_err", t), 64'(n_err - e0), 64'(ee));
      if (nb == 16)
        chk($sformatf("rnd%0d_cipo", t), 64'(cvec()), 64'(ec));
    end

    // reset in the middle of a frame
    e0 = n_err;
    s0 = n_str;
    send_bits(18'h083FF, 9);
    rst_n = 1'b0;
    ncs = 1'b1;
    sclk = 1'b0;
    copi = 1'b0;
    wait_clk(3);
    chk("midrst_regs", 64'(regs_cat()), 64'h0);
    rst_n = 1'b1;
    wait_clk(12);
    chk("midrst_hold", 64'(regs_cat()), 64'h0);
    chk("midrst_err", 64'(n_err - e0), 64'd0);
    chk("midrst_strobe", 64'(n_str - s0), 64'd0);
    frame(18'h083FF, 16);
    chk("postrst_regs", 64'(regs_cat()), 64'h00FF000000);
    chk("postrst_strobe", 64'(n_str - s0), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
